// File: rtl/room_thermal_model.sv
// Behavioural room plant: temperature steps by one degree every STEP_CYCLES
// clocks in the direction chosen by the heating/cooling requests or ambient.
module room_thermal_model #(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned RESET_TEMP  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       heating,
   input  logic       cooling,
   input  logic [4:0] ambient,
   input  logic       set_en,
   input  logic [4:0] set_temp,
   output logic [4:0] temperature,
   output logic [1:0] mode,
   output logic       fault
);

   localparam int unsigned   CW      = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);
   localparam logic [4:0]    RST_T   = 5'(RESET_TEMP);
   localparam logic [4:0]    T_MAX   = 5'd31;

   typedef enum logic [1:0] {
      DRIFT    = 2'b00,
      HEAT     = 2'b01,
      COOL     = 2'b10,
      CONFLICT = 2'b11
   } mode_t;

   mode_t         state;
   mode_t         next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [4:0]    temp_next;
   logic          restart;
   logic          step;
   logic          fault_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DRIFT;
         cnt         <= '0;
         temperature <= RST_T;
         fault       <= 1'b0;
      end else begin
         state       <= next_state;
         cnt         <= cnt_next;
         temperature <= temp_next;
         fault       <= fault_next;
      end
   end

   always_comb begin
      next_state = DRIFT;
      unique case ({cooling, heating})
         2'b01:   next_state = HEAT;
         2'b10:   next_state = COOL;
         2'b11:   next_state = CONFLICT;
         default: next_state = DRIFT;
      endcase

      // a mode change or load restarts the full step interval
      restart = (next_state != state) || set_en;
      step    = !restart && (cnt == CNT_MAX);

      cnt_next = cnt + 1'b1;
      if (restart || (cnt == CNT_MAX)) begin
         cnt_next = '0;
      end

      temp_next = temperature;
      if (set_en) begin
         temp_next = set_temp;
      end else if (step) begin
         unique case (state)
            HEAT: begin
               if (temperature != T_MAX) temp_next = temperature + 5'd1;
            end
            COOL: begin
               if (temperature != 5'd0) temp_next = temperature - 5'd1;
            end
            DRIFT: begin
               if (temperature < ambient)      temp_next = temperature + 5'd1;
               else if (temperature > ambient) temp_next = temperature - 5'd1;
            end
            default: temp_next = temperature;
         endcase
      end

      fault_next = fault | (heating & cooling);
   end

   assign mode = state;

endmodule

// File: tb/tb_room_thermal_model.sv
// Scoreboard bench: the driver pushes model-predicted outputs per edge, the
// monitor pops and compares them just after each rising edge.
module tb_room_thermal_model;

   localparam int unsigned STEP = 4;
   localparam int unsigned RT   = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       heating;
   logic       cooling;
   logic [4:0] ambient;
   logic       set_en;
   logic [4:0] set_temp;
   logic [4:0] temperature;
   logic [1:0] mode;
   logic       fault;

   room_thermal_model #(.STEP_CYCLES(STEP), .RESET_TEMP(RT)) dut (
      .clk(clk), .rst_n(rst_n), .heating(heating), .cooling(cooling),
      .ambient(ambient), .set_en(set_en), .set_temp(set_temp),
      .temperature(temperature), .mode(mode), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] t;
      logic [1:0] m;
      logic       f;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference plant: edges since the last restart, temperature as an integer
   int m_temp;
   int m_mode;
   int m_n;
   bit m_fault;

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_temp  = RT;
      m_mode  = 0;
      m_n     = 0;
      m_fault = 0;
   endtask

   task automatic model_edge(bit h, bit c, int amb, bit se, int st);
      int nm;
      nm = (h && c) ? 3 : h ? 1 : c ? 2 : 0;
      if (se || nm != m_mode) begin
         m_n = 0;
      end else begin
         m_n++;
         if (m_n % STEP == 0) begin
            if (m_mode == 1 && m_temp < 31) m_temp++;
            else if (m_mode == 2 && m_temp > 0) m_temp--;
            else if (m_mode == 0 && m_temp < amb) m_temp++;
            else if (m_mode == 0 && m_temp > amb) m_temp--;
         end
      end
      if (se) m_temp = st;
      m_mode = nm;
      if (h && c) m_fault = 1;
   endtask

   // called just after a falling edge: drive inputs and predict the next edge
   task automatic apply(bit h, bit c, int amb, bit se, int st);
      heating  = h;
      cooling  = c;
      ambient  = 5'(amb);
      set_en   = se;
      set_temp = 5'(st);
      if (!rst_n) model_reset();
      else        model_edge(h, c, amb, se, st);
      sb.push_back(exp_t'{t: 5'(m_temp), m: 2'(m_mode), f: m_fault});
   endtask

   task automatic cyc(bit h, bit c, int amb, bit se, int st);
      apply(h, c, amb, se, st);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_temp", temperature, RT);
      chk("async_rst_mode", mode, 0);
      chk("async_rst_fault", fault, 0);
      #1 rst_n = 1'b1;
      model_reset();
      cyc(heating, cooling, ambient, 1'b0, set_temp);
   endtask

   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_temperature", temperature, e.t);
         chk("sb_mode", mode, e.m);
         chk("sb_fault", fault, e.f);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; heating = 0; cooling = 0; ambient = 20; set_en = 0; set_temp = 0;
      model_reset();
      @(negedge clk);
      cyc(0, 0, 20, 0, 0);
      cyc(0, 0, 20, 0, 0);
      chk("reset_temp", temperature, RT);
      chk("reset_mode", mode, 0);
      chk("reset_fault", fault, 0);
      rst_n = 1'b1;

      // heat: first increment four edges after the mode change, then saturate
      cyc(1, 0, 20, 0, 0);
      chk("heat_mode", mode, 1);
      repeat (3) cyc(1, 0, 20, 0, 0);
      chk("heat_before_step", temperature, 20);
      cyc(1, 0, 20, 0, 0);
      chk("heat_first_step", temperature, 21);
      repeat (4) cyc(1, 0, 20, 0, 0);
      chk("heat_second_step", temperature, 22);
      repeat (60) cyc(1, 0, 20, 0, 0);
      chk("heat_saturate", temperature, 31);

      // load 2 then cool to 0 with no wrap
      cyc(0, 0, 20, 1, 2);
      chk("load_value", temperature, 2);
      repeat (5) cyc(0, 1, 20, 0, 0);
      chk("cool_step1", temperature, 1);
      repeat (4) cyc(0, 1, 20, 0, 0);
      chk("cool_step0", temperature, 0);
      repeat (20) cyc(0, 1, 20, 0, 0);
      chk("cool_saturate", temperature, 0);

      // drift down to ambient 17, then up to 25
      cyc(0, 0, 17, 1, 20);
      repeat (4) cyc(0, 0, 17, 0, 0);
      chk("drift_19", temperature, 19);
      repeat (8) cyc(0, 0, 17, 0, 0);
      chk("drift_17", temperature, 17);
      repeat (20) cyc(0, 0, 17, 0, 0);
      chk("drift_hold", temperature, 17);
      repeat (40) cyc(0, 0, 25, 0, 0);
      chk("drift_25", temperature, 25);

      // reset mid-count during heating
      cyc(0, 0, 25, 1, 20);
      repeat (3) cyc(1, 0, 25, 0, 0);
      pulse_reset();
      repeat (2) cyc(1, 0, 25, 0, 0);
      chk("post_rst_no_early_step", temperature, 20);
      repeat (2) cyc(1, 0, 25, 0, 0);
      chk("post_rst_step", temperature, 21);

      // closed loop with a hysteresis controller driven from the model
      pulse_reset();
      for (int i = 0; i < 600; i++) begin
         cyc(m_temp < 21, m_temp > 23, (i < 300) ? 10 : 31, 0, 0);
         if (i >= 100) begin
            chk("loop_band_lo", int'(temperature >= 5'd20), 1);
            chk("loop_band_hi", int'(temperature <= 5'd24), 1);
         end
      end
      chk("loop_fault", fault, 0);

      // conflict for one cycle, then heating
      cyc(0, 0, 20, 1, 10);
      cyc(1, 1, 20, 0, 0);
      chk("conflict_mode", mode, 3);
      chk("conflict_fault", fault, 1);
      chk("conflict_hold", temperature, 10);
      repeat (4) cyc(1, 0, 20, 0, 0);
      chk("conflict_no_step", temperature, 10);
      cyc(1, 0, 20, 0, 0);
      chk("conflict_resume", temperature, 11);
      repeat (10) cyc(0, 0, 20, 0, 0);
      chk("fault_sticky", fault, 1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int r;
         bit h, c;
         r = int'($urandom_range(0, 99));
         h = (r < 40) || (r >= 95);
         c = (r >= 40 && r < 75) || (r >= 95);
         if ($urandom_range(0, 99) == 0) pulse_reset();
         else cyc(h, c, int'($urandom_range(0, 31)), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 31)));
      end

      cyc(0, 0, 20, 0, 0);
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
